// File: rtl/tc_pl_acp_pkg.sv
// Shared types and AXI constants for the ACP-TX AXI3 write path.
// Statistics outputs on the top are enabled with `define ACP_TX_STAT_EN.
package tc_pl_acp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } acp_state_e;

  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] ACP_CACHE  = 4'b1111;
  localparam logic [4:0] ACP_USER   = 5'b00001;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Beats are 8 bytes wide, so the burst start is forced onto a beat boundary.
  function automatic logic [31:0] align_8b(input logic [31:0] addr);
    return addr & 32'hFFFF_FFF8;
  endfunction

endpackage

// File: rtl/tc_pl_acp_wbuf.sv
// W-data skid FIFO: DEPTH x WIDTH, head visible combinationally the cycle after it is written.
// Writes while full and reads while empty are dropped.
module tc_pl_acp_wbuf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/tc_pl_acp_tx_axi_wr.sv
// ACP-TX burst request + wdreq-paced data -> single-outstanding AXI3 INCR write bursts.
// `define ACP_TX_STAT_EN adds stat_bursts / stat_errs counters and ports.
module tc_pl_acp_tx_axi_wr
  import tc_pl_acp_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acp0_tx_en,
  output logic        acp0_tx_rdy,
  input  logic [31:0] acp0_tx_awaddr,
  input  logic [2:0]  acp0_tx_awid,
  input  logic [63:0] acp0_tx_wdata,
  output logic        acp0_tx_wdreq,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awid,
  output logic [3:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic [3:0]  m_axi_awcache,
  output logic [4:0]  m_axi_awuser,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        acp_err
`ifdef ACP_TX_STAT_EN
  ,
  output logic [31:0] stat_bursts,
  output logic [15:0] stat_errs
`endif
);

  localparam int CNT_W  = $clog2(BURST_LEN+1);
  localparam int FCNT_W = $clog2(WBUF_DEPTH+1);
  localparam logic [CNT_W-1:0]  LEN_C   = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(BURST_LEN-1);
  localparam logic [FCNT_W:0]   DEPTH_C = (FCNT_W+1)'(WBUF_DEPTH);

  acp_state_e       state_q, state_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [2:0]       awid_q, awid_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             inflight_q, inflight_d;
  logic             err_q, err_d;
`ifdef ACP_TX_STAT_EN
  logic [31:0]      stat_bursts_q, stat_bursts_d;
  logic [15:0]      stat_errs_q, stat_errs_d;
`endif

  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [FCNT_W:0]   fifo_occ;
  logic              beat_hs;
  logic              last_beat;

  tc_pl_acp_wbuf #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (64)
  ) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_q),
    .wr_data (acp0_tx_wdata),
    .rd_en   (beat_hs),
    .rd_data (m_axi_wdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // A beat requested last cycle is already committed to the FIFO, so it counts as occupied.
  assign fifo_occ      = {1'b0, fifo_cnt} + (FCNT_W+1)'(inflight_q);
  assign m_axi_wvalid  = ~fifo_empty;
  assign beat_hs       = m_axi_wvalid & m_axi_wready;
  assign last_beat     = (beat_cnt_q == LAST_C);
  assign m_axi_wlast   = m_axi_wvalid & last_beat;
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awid    = awid_q;
  assign m_axi_awlen   = 4'(BURST_LEN-1);
  assign m_axi_awsize  = SIZE_8B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awcache = ACP_CACHE;
  assign m_axi_awuser  = ACP_USER;
  assign acp_err       = err_q;
`ifdef ACP_TX_STAT_EN
  assign stat_bursts   = stat_bursts_q;
  assign stat_errs     = stat_errs_q;
`endif

  always_comb begin
    state_d       = state_q;
    awaddr_d      = awaddr_q;
    awid_d        = awid_q;
    req_cnt_d     = req_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q;
    acp0_tx_rdy   = 1'b0;
    acp0_tx_wdreq = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_bready  = 1'b0;
`ifdef ACP_TX_STAT_EN
    stat_bursts_d = stat_bursts_q;
    stat_errs_d   = stat_errs_q;
`endif
    case (state_q)
      ST_IDLE: begin
        acp0_tx_rdy = 1'b1;
        if (acp0_tx_en) begin
          awaddr_d   = align_8b(acp0_tx_awaddr);
          awid_d     = acp0_tx_awid;
          req_cnt_d  = '0;
          beat_cnt_d = '0;
          state_d    = ST_AW;
        end
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        acp0_tx_wdreq = (req_cnt_q < LEN_C) && (fifo_occ < DEPTH_C);
        if (acp0_tx_wdreq) req_cnt_d = req_cnt_q + 1'b1;
        if (beat_hs) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY) err_d = 1'b1;
`ifdef ACP_TX_STAT_EN
          stat_bursts_d = stat_bursts_q + 32'd1;
          if (m_axi_bresp != RESP_OKAY && stat_errs_q != 16'hFFFF)
            stat_errs_d = stat_errs_q + 16'd1;
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d = acp0_tx_wdreq;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      awaddr_q      <= '0;
      awid_q        <= '0;
      req_cnt_q     <= '0;
      beat_cnt_q    <= '0;
      inflight_q    <= 1'b0;
      err_q         <= 1'b0;
`ifdef ACP_TX_STAT_EN
      stat_bursts_q <= '0;
      stat_errs_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      awaddr_q      <= awaddr_d;
      awid_q        <= awid_d;
      req_cnt_q     <= req_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      inflight_q    <= inflight_d;
      err_q         <= err_d;
`ifdef ACP_TX_STAT_EN
      stat_bursts_q <= stat_bursts_d;
      stat_errs_q   <= stat_errs_d;
`endif
    end
  end

endmodule
